// File: rtl/aes128_pkg.sv
// Shared definitions for the AES-128 CBC stream front end: FSM encoding,
// block geometry and a word-select helper.
package aes128_pkg;

  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 4;
  localparam int BLOCK_W     = WORD_W * BLOCK_WORDS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Word 3 is the most significant 32 bits of the block.
  function automatic logic [WORD_W-1:0] block_word(input logic [BLOCK_W-1:0] blk,
                                                   input logic [1:0]         idx);
    return blk[idx*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/aes128_word_unpacker.sv
// 128-bit to 32-bit serializer: latches a plaintext block and emits it
// most significant word first under valid/ready handshaking.
module aes128_word_unpacker
  import aes128_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [BLOCK_W-1:0] block,
  input  logic               last,
  input  logic               m_ready,
  output logic [WORD_W-1:0]  m_data,
  output logic               m_valid,
  output logic               m_last,
  output logic               done
);

  logic [BLOCK_W-1:0] pt_reg;
  logic               last_reg;
  logic [1:0]         word_cnt;
  logic [1:0]         word_sel;
  logic               active;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pt_reg   <= '0;
      last_reg <= 1'b0;
      word_cnt <= 2'd0;
      active   <= 1'b0;
    end else if (load) begin
      pt_reg   <= block;
      last_reg <= last;
      word_cnt <= 2'd0;
      active   <= 1'b1;
    end else if (active && m_ready) begin
      word_cnt <= word_cnt + 2'd1;
      if (word_cnt == 2'd3)
        active <= 1'b0;
    end
  end

  // Count 0..3 maps onto words 3..0; data comes straight from registers so it
  // cannot move while the consumer stalls.
  assign word_sel = ~word_cnt;
  assign m_data   = block_word(pt_reg, word_sel);
  assign m_valid  = active;
  assign m_last   = active && last_reg && (word_cnt == 2'd3);
  assign done     = active && m_ready && (word_cnt == 2'd3);

endmodule

// File: rtl/aes128_cbc_stream_adapter.sv
// Word-stream front end for the AES-128 CBC decryptor: assembles cipher
// blocks, supplies the chaining vector, waits out the decrypt latency, drains plaintext.
module aes128_cbc_stream_adapter
  import aes128_pkg::*;
#(
  parameter int DEC_LATENCY = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] iv_0,
  input  logic [WORD_W-1:0] iv_1,
  input  logic [WORD_W-1:0] iv_2,
  input  logic [WORD_W-1:0] iv_3,
  input  logic              iv_load,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [WORD_W-1:0] cipher_text_0,
  output logic [WORD_W-1:0] cipher_text_1,
  output logic [WORD_W-1:0] cipher_text_2,
  output logic [WORD_W-1:0] cipher_text_3,
  output logic [WORD_W-1:0] vector_0,
  output logic [WORD_W-1:0] vector_1,
  output logic [WORD_W-1:0] vector_2,
  output logic [WORD_W-1:0] vector_3,
  input  logic [WORD_W-1:0] decrypted_plain_text_0,
  input  logic [WORD_W-1:0] decrypted_plain_text_1,
  input  logic [WORD_W-1:0] decrypted_plain_text_2,
  input  logic [WORD_W-1:0] decrypted_plain_text_3,
  output logic              busy
);

  localparam int              LAT_W    = (DEC_LATENCY > 1) ? $clog2(DEC_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(DEC_LATENCY - 1);

  state_t             state, state_next;
  logic [BLOCK_W-1:0] iv_reg;
  logic [BLOCK_W-1:0] chain_reg;
  logic [BLOCK_W-1:0] ct_reg;
  logic [1:0]         word_cnt;
  logic [1:0]         word_slot;
  logic [LAT_W-1:0]   lat_cnt;
  logic               last_reg;
  logic               s_fire;
  logic               lat_done;
  logic               drain_done;

  assign s_fire    = s_valid && s_ready;
  assign lat_done  = (state == WAIT) && (lat_cnt == LAT_LAST);
  assign word_slot = ~word_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (iv_load) state_next = FILL;
      FILL:  if (s_fire && (word_cnt == 2'd3)) state_next = WAIT;
      WAIT:  if (lat_done) state_next = DRAIN;
      DRAIN: if (drain_done) state_next = last_reg ? IDLE : FILL;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    if (state == FILL)
      s_ready = 1'b1;
    if (state != IDLE)
      busy = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iv_reg    <= '0;
      chain_reg <= '0;
      ct_reg    <= '0;
      word_cnt  <= 2'd0;
      lat_cnt   <= '0;
      last_reg  <= 1'b0;
    end else begin
      if ((state == IDLE) && iv_load) begin
        iv_reg    <= {iv_3, iv_2, iv_1, iv_0};
        chain_reg <= {iv_3, iv_2, iv_1, iv_0};
      end
      if (s_fire) begin
        ct_reg[word_slot*WORD_W +: WORD_W] <= s_data;
        word_cnt <= word_cnt + 2'd1;
        if (word_cnt == 2'd3)
          last_reg <= s_last;
      end
      if (state == WAIT)
        lat_cnt <= lat_done ? '0 : lat_cnt + 1'b1;
      // The block just decrypted becomes the vector for the next one; a
      // finished message rewinds to its IV.
      if (lat_done)
        chain_reg <= ct_reg;
      if (drain_done && last_reg)
        chain_reg <= iv_reg;
    end
  end

  aes128_word_unpacker u_unpacker (
    .clk     (clk),
    .reset   (reset),
    .load    (lat_done),
    .block   ({decrypted_plain_text_3, decrypted_plain_text_2,
               decrypted_plain_text_1, decrypted_plain_text_0}),
    .last    (last_reg),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_last  (m_last),
    .done    (drain_done)
  );

  assign cipher_text_3 = ct_reg[127:96];
  assign cipher_text_2 = ct_reg[95:64];
  assign cipher_text_1 = ct_reg[63:32];
  assign cipher_text_0 = ct_reg[31:0];
  assign vector_3      = chain_reg[127:96];
  assign vector_2      = chain_reg[95:64];
  assign vector_1      = chain_reg[63:32];
  assign vector_0      = chain_reg[31:0];

endmodule

// File: tb/tb_aes128_cbc_stream_adapter.sv
// Scoreboard bench for the CBC stream adapter with an XOR stand-in for the decryptor.
module tb_aes128_cbc_stream_adapter;

  localparam int LAT = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] iv_0, iv_1, iv_2, iv_3;
  logic        iv_load;
  logic [31:0] s_data;
  logic        s_valid, s_ready, s_last;
  logic [31:0] m_data;
  logic        m_valid, m_ready, m_last;
  logic [31:0] cipher_text_0, cipher_text_1, cipher_text_2, cipher_text_3;
  logic [31:0] vector_0, vector_1, vector_2, vector_3;
  logic [31:0] decrypted_plain_text_0, decrypted_plain_text_1;
  logic [31:0] decrypted_plain_text_2, decrypted_plain_text_3;
  logic        busy;

  always #5 clk = ~clk;

  aes128_cbc_stream_adapter #(.DEC_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .iv_0(iv_0), .iv_1(iv_1), .iv_2(iv_2), .iv_3(iv_3), .iv_load(iv_load),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .cipher_text_0(cipher_text_0), .cipher_text_1(cipher_text_1),
    .cipher_text_2(cipher_text_2), .cipher_text_3(cipher_text_3),
    .vector_0(vector_0), .vector_1(vector_1), .vector_2(vector_2), .vector_3(vector_3),
    .decrypted_plain_text_0(decrypted_plain_text_0),
    .decrypted_plain_text_1(decrypted_plain_text_1),
    .decrypted_plain_text_2(decrypted_plain_text_2),
    .decrypted_plain_text_3(decrypted_plain_text_3),
    .busy(busy)
  );

  // Decryptor stand-in: plaintext = cipher XOR vector.
  assign decrypted_plain_text_0 = cipher_text_0 ^ vector_0;
  assign decrypted_plain_text_1 = cipher_text_1 ^ vector_1;
  assign decrypted_plain_text_2 = cipher_text_2 ^ vector_2;
  assign decrypted_plain_text_3 = cipher_text_3 ^ vector_3;

  wire [127:0] ct_all  = {cipher_text_3, cipher_text_2, cipher_text_1, cipher_text_0};
  wire [127:0] vec_all = {vector_3, vector_2, vector_1, vector_0};

  localparam logic [127:0] IV_A  = 128'h132f5f00c90d7f84edda7ac61de0082e;
  localparam logic [127:0] BLK_A = 128'h46d2d2cb06f40c41b08b25b97a6fa062;
  localparam logic [127:0] PT_A  = 128'h55fd8dcbcff973c55d515f7f678fa84c;

  logic [32:0]  exp_q[$];
  logic [32:0]  exp_word;
  int           errors = 0;
  int           checks = 0;
  int           accepts = 0;
  logic [127:0] iv_model, chain_model;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (s_valid && s_ready)
      accepts++;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("out_queue_nonempty", exp_q.size(), 1);
      end else begin
        exp_word = exp_q.pop_front();
        check("out_word", {m_last, m_data}, exp_word);
      end
    end
  end

  task automatic load_iv(input logic [127:0] iv);
    int n = 0;
    while (busy && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) check("idle_timeout", busy, 0);
    {iv_3, iv_2, iv_1, iv_0} = iv;
    iv_load = 1'b1;
    @(posedge clk); #1;
    iv_load = 1'b0;
    iv_model    = iv;
    chain_model = iv;
  endtask

  task automatic send_block(input logic [127:0] blk, input logic [127:0] exp_pt,
                            input bit last, input bit gaps, input bit w2_last,
                            input bit poke_iv);
    int n;
    int a0 = accepts;
    for (int i = 0; i < 4; i++) begin
      s_data  = blk[127-32*i -: 32];
      s_last  = (i == 3) ? last : (i == 1 && w2_last);
      s_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_ready && n < 1000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 1000) check("s_ready_timeout", s_ready, 1);
      @(posedge clk); #1;
      if (gaps && i < 3) begin
        s_valid = 1'b0;
        s_data  = 32'hdeadbeef;
        s_last  = 1'b1;
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    for (int i = 0; i < 4; i++)
      exp_q.push_back({(last && i == 3), exp_pt[127-32*i -: 32]});
    if (poke_iv) begin
      {iv_3, iv_2, iv_1, iv_0} = ~iv_model;
      iv_load = 1'b1;
    end
    n = 0;
    @(negedge clk);
    check("cipher_block", ct_all, blk);
    while (!m_valid && n < LAT + 20) begin
      check("vector_hold", vec_all, chain_model);
      check("s_ready_wait", s_ready, 0);
      @(negedge clk);
      n++;
      if (n >= 1) iv_load = 1'b0;
    end
    check("latency", n, LAT);
    check("accepts", accepts - a0, 4);
    chain_model = last ? iv_model : blk;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    logic [127:0] iv_r, blk_r, blk_s;
    logic [31:0]  hold;
    reset = 1'b0; iv_load = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    s_data = '0; m_ready = 1'b1;
    {iv_3, iv_2, iv_1, iv_0} = '0;
    iv_model = '0; chain_model = '0;
    #23;
    check("reset_ctrl", {s_ready, m_valid, m_last, busy, m_data}, 0);
    check("reset_cipher", ct_all, 0);
    check("reset_vector", vec_all, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Single block with last
    load_iv(IV_A);
    send_block(BLK_A, PT_A, 1, 0, 0, 0);
    wait_drain();
    check("idle_after_last", busy, 0);

    // Two-block chaining; s_last on word 2 of block 1 must be ignored
    load_iv(IV_A);
    send_block(BLK_A, PT_A, 0, 0, 1, 0);
    check("chain_literal", chain_model, BLK_A);
    send_block(128'h0, BLK_A, 1, 0, 0, 0);
    wait_drain();
    check("idle_after_chain", busy, 0);

    // Backpressure on the second output word
    iv_r  = {$urandom, $urandom, $urandom, $urandom};
    blk_r = {$urandom, $urandom, $urandom, $urandom};
    load_iv(iv_r);
    m_ready = 1'b0;
    send_block(blk_r, blk_r ^ iv_r, 1, 0, 0, 0);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    hold = m_data;
    check("bp_word", {m_last, hold}, exp_q[0]);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_data_stable", m_data, hold);
      check("bp_valid_held", m_valid, 1);
      check("bp_s_ready", s_ready, 0);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_drain();

    // Input gaps plus an iv_load during WAIT, then a chained block
    iv_r  = {$urandom, $urandom, $urandom, $urandom};
    blk_r = {$urandom, $urandom, $urandom, $urandom};
    blk_s = {$urandom, $urandom, $urandom, $urandom};
    load_iv(iv_r);
    send_block(blk_r, blk_r ^ iv_r, 0, 1, 0, 1);
    send_block(blk_s, blk_s ^ blk_r, 1, 0, 0, 0);
    wait_drain();

    // Reset after two words, then a fresh message
    iv_r = {$urandom, $urandom, $urandom, $urandom};
    load_iv(iv_r);
    for (int i = 0; i < 2; i++) begin
      s_data  = $urandom;
      s_valid = 1'b1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    reset = 1'b0;
    #2;
    check("midrst_ctrl", {s_ready, m_valid, m_last, busy, m_data}, 0);
    check("midrst_cipher", ct_all, 0);
    check("midrst_vector", vec_all, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    iv_r  = {$urandom, $urandom, $urandom, $urandom};
    blk_r = {$urandom, $urandom, $urandom, $urandom};
    load_iv(iv_r);
    send_block(blk_r, blk_r ^ iv_r, 1, 0, 0, 0);
    wait_drain();
    check("idle_final", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
